hiscore_ram_arbiter: RTL and testbench
======================================

Name: hiscore_ram_arbiter

Overview:
- Shares the single-port CPU work RAM between the game CPU and the hiscore engine.
- Sequences a pause handshake with the pause block: request pause, wait for the CPU to be halted and its bus idle, then grant the RAM to the hiscore engine.
- Returns the RAM to the CPU and releases the pause after a hold-off.
- Sits between the game core's CPU RAM port and the hiscore module (hs_address / hs_data_* / hs_write / intent signals).

Parameters:
- AW, 16, RAM/hiscore address width.
- SETTLE, 4, cycles to wait after paused && !cpu_cs before granting.
- HOLDOFF, 8, cycles after the last hiscore intent drops before pause_req is released.
- TIMEOUT, 65535, cycles to wait for paused before aborting.

Ports:
- clkm_36MHZ  in  1  system clock.
- RESET_n  in  1  asynchronous active-low reset.
- cpu_addr  in  AW  CPU RAM address.
- cpu_din  in  8  CPU write data.
- cpu_we  in  1  CPU write strobe.
- cpu_cs  in  1  CPU RAM select (bus active).
- cpu_dout  out  8  RAM read data to CPU.
- hs_access_read  in  1  hiscore read intent.
- hs_access_write  in  1  hiscore write intent.
- hs_address  in  AW  hiscore address.
- hs_data_in  in  8  hiscore write data.
- hs_write  in  1  hiscore write strobe.
- hs_data_out  out  8  registered RAM read data to hiscore.
- hs_grant  out  1  RAM owned by hiscore.
- hs_error  out  1  sticky pause-timeout flag.
- pause_req  out  1  pause request to pause block.
- paused  in  1  CPU halted acknowledge.
- ram_addr  out  AW  RAM address.
- ram_din  out  8  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_dout  in  8  RAM read data, 1-cycle synchronous latency.

Behaviour:
- Reset (async, RESET_n=0): state=IDLE; pause_req=0, hs_grant=0, hs_error=0, hs_data_out=0, settle/holdoff/timeout counters=0.
  - Reset mid-operation aborts any grant immediately; the RAM mux reverts to the CPU.
- intent = hs_access_read | hs_access_write.
- RAM mux (combinational on the hs_grant register):
  - hs_grant=0: ram_addr=cpu_addr, ram_din=cpu_din, ram_we=cpu_we&cpu_cs.
  - hs_grant=1: ram_addr=hs_address, ram_din=hs_data_in, ram_we=hs_write. CPU writes are blocked.
  - cpu_dout=ram_dout always.
- hs_data_out <= ram_dout every cycle hs_grant=1; holds its value otherwise. Hiscore read data is valid 2 cycles after the address is presented (1 RAM + 1 register).
- FSM states:
  - IDLE: intent=1 -> REQ; pause_req<=1; timeout counter cleared.
  - REQ:
    - paused=1 && cpu_cs=0 -> SETTLE with settle counter=0.
    - intent=0 -> RELEASE.
    - Timeout counter reaches TIMEOUT -> RELEASE and hs_error<=1.
  - SETTLE: counter increments each cycle.
    - Restarts at 0 if cpu_cs=1 or paused=0.
    - Reaching SETTLE-1 -> GRANT; hs_grant<=1.
    - intent=0 -> RELEASE.
  - GRANT: hs_grant=1.
    - Stays while intent=1.
    - intent=0 -> HOLD; hs_grant<=0 on the same edge.
  - HOLD: hs_grant=0, pause_req=1, holdoff counter counts.
    - intent=1 before expiry -> back to SETTLE. Re-acquire without dropping pause.
    - Counter reaches HOLDOFF-1 -> RELEASE.
  - RELEASE: pause_req<=0 -> IDLE next cycle. This guarantees at least one cycle of pause_req=0 between sessions.
- hs_write while hs_grant=0 is ignored: no RAM write occurs.
- paused falling while in GRANT: hs_grant stays 1. Ownership is held by the FSM, not by paused.
- hs_error clears only on reset.

Test Plan:
- Reset: assert RESET_n=0 mid-GRANT -> same cycle hs_grant=0, pause_req=0, ram_addr=cpu_addr; after release, state IDLE.
- Normal read:
  - Stimulus: intent up; paused=1 after 10 cycles with cpu_cs=0; hs_address=0x8A00 while RAM[0x8A00]=0x5C.
  - Required: pause_req rises 1 cycle after intent; hs_grant rises SETTLE cycles after paused; hs_data_out=0x5C 2 cycles after address.
- Write and blocking:
  - Stimulus: in GRANT, hs_write=1 @0x8A10 data 0x33, while CPU drives cpu_we=1 @0x8A10 data 0xFF.
  - Required: RAM[0x8A10]=0x33.
- Settle restart: pulse cpu_cs=1 for 1 cycle during SETTLE -> grant is delayed by the full SETTLE count from the pulse.
- Hold-off reuse: intent drops, then returns after 3 cycles (HOLDOFF=8) -> pause_req never deasserts; hs_grant returns after SETTLE.
- Timeout (TIMEOUT=100): intent=1, paused held 0 -> at cycle 100 pause_req=0 and hs_error=1 (sticky); RAM stays with the CPU.

Source files
------------

// File: rtl/hiscore_ram_arbiter.sv
// Arbitrates the single-port CPU work RAM between the game CPU and the hiscore
// engine, pausing the CPU around every hiscore access session.
module hiscore_ram_arbiter #(
    parameter int AW      = 16,
    parameter int SETTLE  = 4,
    parameter int HOLDOFF = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic          clkm_36MHZ,
    input  logic          RESET_n,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    input  logic          cpu_we,
    input  logic          cpu_cs,
    output logic [7:0]    cpu_dout,
    input  logic          hs_access_read,
    input  logic          hs_access_write,
    input  logic [AW-1:0] hs_address,
    input  logic [7:0]    hs_data_in,
    input  logic          hs_write,
    output logic [7:0]    hs_data_out,
    output logic          hs_grant,
    output logic          hs_error,
    output logic          pause_req,
    input  logic          paused,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_din,
    output logic          ram_we,
    input  logic [7:0]    ram_dout
);
    localparam int SW = $clog2(SETTLE + 1);
    localparam int HW = $clog2(HOLDOFF + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE - 1);
    localparam logic [HW-1:0] HOLD_LAST    = HW'(HOLDOFF - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_SETTLE,
        ST_GRANT,
        ST_HOLD,
        ST_RELEASE
    } state_t;

    state_t        state_reg, state_next;
    logic          pause_req_reg, pause_req_next;
    logic          hs_grant_reg, hs_grant_next;
    logic          hs_error_reg, hs_error_next;
    logic [7:0]    hs_data_out_reg;
    logic [SW-1:0] settle_cnt_reg, settle_cnt_next;
    logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
    logic [TW-1:0] timeout_cnt_reg, timeout_cnt_next;

    logic          intent;
    logic          bus_quiet;
    logic [SW-1:0] settle_inc;

    assign intent     = hs_access_read | hs_access_write;
    assign bus_quiet  = paused & ~cpu_cs;
    assign settle_inc = settle_cnt_reg + SW'(1);

    // Ownership follows the registered grant only, so the CPU path is never
    // glitched by combinational handshake inputs.
    assign ram_addr = hs_grant_reg ? hs_address : cpu_addr;
    assign ram_din  = hs_grant_reg ? hs_data_in : cpu_din;
    assign ram_we   = hs_grant_reg ? hs_write   : (cpu_we & cpu_cs);
    assign cpu_dout = ram_dout;

    assign hs_data_out = hs_data_out_reg;
    assign hs_grant    = hs_grant_reg;
    assign hs_error    = hs_error_reg;
    assign pause_req   = pause_req_reg;

    always_comb begin
        state_next       = state_reg;
        pause_req_next   = pause_req_reg;
        hs_grant_next    = hs_grant_reg;
        hs_error_next    = hs_error_reg;
        settle_cnt_next  = settle_cnt_reg;
        hold_cnt_next    = hold_cnt_reg;
        timeout_cnt_next = timeout_cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (intent) begin
                    state_next       = ST_REQ;
                    pause_req_next   = 1'b1;
                    timeout_cnt_next = '0;
                end
            end
            ST_REQ: begin
                if (!intent) begin
                    state_next     = ST_RELEASE;
                    pause_req_next = 1'b0;
                end else if (bus_quiet) begin
                    state_next      = ST_SETTLE;
                    settle_cnt_next = '0;
                end else if (timeout_cnt_reg == TIMEOUT_LAST) begin
                    state_next     = ST_RELEASE;
                    pause_req_next = 1'b0;
                    hs_error_next  = 1'b1;
                end else begin
                    timeout_cnt_next = timeout_cnt_reg + TW'(1);
                end
            end
            ST_SETTLE: begin
                if (!intent) begin
                    state_next     = ST_RELEASE;
                    pause_req_next = 1'b0;
                end else if (!bus_quiet) begin
                    settle_cnt_next = '0;
                end else if (settle_inc == SETTLE_LAST) begin
                    state_next      = ST_GRANT;
                    hs_grant_next   = 1'b1;
                    settle_cnt_next = settle_inc;
                end else begin
                    settle_cnt_next = settle_inc;
                end
            end
            ST_GRANT: begin
                // A falling paused does not revoke ownership mid-session.
                if (!intent) begin
                    state_next    = ST_HOLD;
                    hs_grant_next = 1'b0;
                    hold_cnt_next = '0;
                end
            end
            ST_HOLD: begin
                if (intent) begin
                    state_next      = ST_SETTLE;
                    settle_cnt_next = '0;
                end else if (hold_cnt_reg == HOLD_LAST) begin
                    state_next     = ST_RELEASE;
                    pause_req_next = 1'b0;
                end else begin
                    hold_cnt_next = hold_cnt_reg + HW'(1);
                end
            end
            ST_RELEASE: begin
                state_next     = ST_IDLE;
                pause_req_next = 1'b0;
            end
            default: begin
                state_next     = ST_IDLE;
                pause_req_next = 1'b0;
                hs_grant_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clkm_36MHZ or negedge RESET_n) begin
        if (!RESET_n) begin
            state_reg       <= ST_IDLE;
            pause_req_reg   <= 1'b0;
            hs_grant_reg    <= 1'b0;
            hs_error_reg    <= 1'b0;
            hs_data_out_reg <= 8'h00;
            settle_cnt_reg  <= '0;
            hold_cnt_reg    <= '0;
            timeout_cnt_reg <= '0;
        end else begin
            state_reg       <= state_next;
            pause_req_reg   <= pause_req_next;
            hs_grant_reg    <= hs_grant_next;
            hs_error_reg    <= hs_error_next;
            settle_cnt_reg  <= settle_cnt_next;
            hold_cnt_reg    <= hold_cnt_next;
            timeout_cnt_reg <= timeout_cnt_next;
            if (hs_grant_reg) begin
                hs_data_out_reg <= ram_dout;
            end
        end
    end
endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Self-checking bench for hiscore_ram_arbiter: vector tables, directed
// corner-case sequences and a randomized run against a session-level model.
module tb_hiscore_ram_arbiter;
    localparam int AW      = 16;
    localparam int SETTLE  = 4;
    localparam int HOLDOFF = 8;
    localparam int TIMEOUT = 100;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din;
    logic          cpu_we;
    logic          cpu_cs;
    logic [7:0]    cpu_dout;
    logic          hs_access_read;
    logic          hs_access_write;
    logic [AW-1:0] hs_address;
    logic [7:0]    hs_data_in;
    logic          hs_write;
    logic [7:0]    hs_data_out;
    logic          hs_grant;
    logic          hs_error;
    logic          pause_req;
    logic          paused;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;
    logic          ram_we;
    logic [7:0]    ram_dout;

    hiscore_ram_arbiter #(
        .AW(AW), .SETTLE(SETTLE), .HOLDOFF(HOLDOFF), .TIMEOUT(TIMEOUT)
    ) dut (
        .clkm_36MHZ(clk), .RESET_n(rst_n),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we), .cpu_cs(cpu_cs),
        .cpu_dout(cpu_dout),
        .hs_access_read(hs_access_read), .hs_access_write(hs_access_write),
        .hs_address(hs_address), .hs_data_in(hs_data_in), .hs_write(hs_write),
        .hs_data_out(hs_data_out), .hs_grant(hs_grant), .hs_error(hs_error),
        .pause_req(pause_req), .paused(paused),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Work RAM: synchronous, read-old-data, one cycle latency.
    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;
    bit mem_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Session-level model: which party owns the RAM and how long each phase lasts.
    localparam int M_OFF = 0, M_ASK = 1, M_SETTLE = 2, M_OWN = 3, M_LINGER = 4, M_COOL = 5;
    int         m_mode, m_wait, m_run, m_linger;
    bit         m_pause, m_grant, m_err;
    logic [7:0] m_out, m_rd;
    logic [7:0] shadow [0:65535];

    task automatic model_reset();
        m_mode = M_OFF; m_wait = 0; m_run = 0; m_linger = 0;
        m_pause = 0; m_grant = 0; m_err = 0; m_out = 8'h00;
    endtask

    task automatic end_session();
        m_mode  = M_COOL;
        m_pause = 0;
    endtask

    task automatic model_step();
        logic [15:0] a;
        logic [7:0]  d;
        logic        we;
        bit          intent, quiet;
        a  = m_grant ? hs_address : cpu_addr;
        d  = m_grant ? hs_data_in : cpu_din;
        we = m_grant ? hs_write : (cpu_we & cpu_cs);
        if (m_grant) m_out = m_rd;
        m_rd = shadow[a];
        if (we) shadow[a] = d;
        if (!rst_n) return;
        intent = hs_access_read | hs_access_write;
        quiet  = paused & ~cpu_cs;
        case (m_mode)
            M_OFF: if (intent) begin m_mode = M_ASK; m_pause = 1; m_wait = 0; end
            M_ASK: begin
                if (!intent) end_session();
                else if (quiet) begin m_mode = M_SETTLE; m_run = 0; end
                else begin
                    m_wait++;
                    if (m_wait == TIMEOUT) begin m_err = 1; end_session(); end
                end
            end
            M_SETTLE: begin
                if (!intent) end_session();
                else if (!quiet) m_run = 0;
                else begin
                    m_run++;
                    if (m_run == SETTLE - 1) begin m_mode = M_OWN; m_grant = 1; end
                end
            end
            M_OWN: if (!intent) begin m_mode = M_LINGER; m_grant = 0; m_linger = 0; end
            M_LINGER: begin
                if (intent) begin m_mode = M_SETTLE; m_run = 0; end
                else begin
                    m_linger++;
                    if (m_linger == HOLDOFF) end_session();
                end
            end
            default: m_mode = M_OFF;
        endcase
    endtask

    task automatic check_model();
        chk("pause_req", pause_req, m_pause);
        chk("hs_grant", hs_grant, m_grant);
        chk("hs_error", hs_error, m_err);
        chk("hs_data_out", hs_data_out, m_out);
        chk("ram_addr", ram_addr, m_grant ? hs_address : cpu_addr);
        chk("ram_din", ram_din, m_grant ? hs_data_in : cpu_din);
        chk("ram_we", ram_we, m_grant ? hs_write : (cpu_we & cpu_cs));
        if (mem_ready) chk("cpu_dout", cpu_dout, m_rd);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    typedef struct {
        logic [15:0] c_addr;
        logic [7:0]  c_din;
        logic        c_we;
        logic        c_cs;
        logic [15:0] h_addr;
        logic [7:0]  h_din;
        logic        h_we;
        logic [15:0] e_addr;
        logic [7:0]  e_din;
        logic        e_we;
    } vec_t;
    vec_t vecs [8];

    task automatic apply_vec(input int i);
        cpu_addr = vecs[i].c_addr; cpu_din = vecs[i].c_din;
        cpu_we = vecs[i].c_we; cpu_cs = vecs[i].c_cs;
        hs_address = vecs[i].h_addr; hs_data_in = vecs[i].h_din; hs_write = vecs[i].h_we;
        #1;
        chk($sformatf("vec%0d_addr", i), ram_addr, vecs[i].e_addr);
        chk($sformatf("vec%0d_din", i), ram_din, vecs[i].e_din);
        chk($sformatf("vec%0d_we", i), ram_we, vecs[i].e_we);
        $display("vec %0d: ram_addr=%h ram_din=%h ram_we=%0d", i, ram_addr, ram_din, ram_we);
        step();
    endtask

    initial begin
        int  k;
        bit  flag;
        vecs[0] = '{16'h8A01, 8'h11, 1'b1, 1'b1, 16'h1234, 8'hAA, 1'b1, 16'h8A01, 8'h11, 1'b1};
        vecs[1] = '{16'h8A02, 8'h22, 1'b1, 1'b0, 16'h1234, 8'hAA, 1'b1, 16'h8A02, 8'h22, 1'b0};
        vecs[2] = '{16'h8A03, 8'h33, 1'b0, 1'b1, 16'h1234, 8'hAA, 1'b1, 16'h8A03, 8'h33, 1'b0};
        vecs[3] = '{16'h8A04, 8'h44, 1'b0, 1'b0, 16'h1235, 8'hBB, 1'b0, 16'h8A04, 8'h44, 1'b0};
        vecs[4] = '{16'h8A10, 8'hFF, 1'b1, 1'b1, 16'h8A10, 8'h33, 1'b1, 16'h8A10, 8'h33, 1'b1};
        vecs[5] = '{16'h8A11, 8'hEE, 1'b1, 1'b1, 16'h8A12, 8'h77, 1'b0, 16'h8A12, 8'h77, 1'b0};
        vecs[6] = '{16'h8A13, 8'hDD, 1'b0, 1'b0, 16'h8A14, 8'h99, 1'b1, 16'h8A14, 8'h99, 1'b1};
        vecs[7] = '{16'h8A15, 8'h00, 1'b1, 1'b1, 16'h8A16, 8'h00, 1'b0, 16'h8A16, 8'h00, 1'b0};

        for (int i = 0; i < 65536; i++) shadow[i] = 8'h00;
        rst_n = 1'b0; cpu_addr = 16'h8A00; cpu_din = 8'h00; cpu_we = 0; cpu_cs = 0;
        hs_access_read = 0; hs_access_write = 0; hs_address = 16'h8A00;
        hs_data_in = 8'h00; hs_write = 0; paused = 0;
        model_reset();
        #22;
        chk("rst_pause_req", pause_req, 1'b0);
        chk("rst_hs_grant", hs_grant, 1'b0);
        chk("rst_hs_error", hs_error, 1'b0);
        chk("rst_hs_data_out", hs_data_out, 8'h00);
        rst_n = 1'b1;
        step();

        // Preload the working region through the CPU port.
        cpu_we = 1; cpu_cs = 1;
        for (int i = 0; i < 32; i++) begin
            cpu_addr = 16'h8A00 + 16'(i);
            cpu_din  = (i == 0) ? 8'h5C : 8'(i * 7 + 3);
            step();
        end
        cpu_we = 0; cpu_cs = 0;
        step(); step();
        mem_ready = 1'b1;

        for (int i = 0; i < 4; i++) apply_vec(i);

        // Normal read session.
        cpu_we = 0; cpu_cs = 0; hs_write = 0; cpu_addr = 16'h8A04; hs_address = 16'h8A00;
        hs_access_read = 1;
        step();
        chk("pause_rise", pause_req, 1'b1);
        repeat (9) step();
        paused = 1;
        k = 0;
        while (!hs_grant && k < 20) begin step(); k++; end
        chk("grant_latency", k, SETTLE);
        $display("grant after %0d cycles of paused", k);
        step(); step();
        chk("read_8A00", hs_data_out, 8'h5C);

        for (int i = 4; i < 8; i++) apply_vec(i);
        hs_write = 0; cpu_we = 0; cpu_cs = 0; hs_address = 16'h8A10;
        step(); step();
        chk("read_8A10", hs_data_out, 8'h33);
        chk("cpu_write_blocked", mem[16'h8A10], 8'h33);

        // paused dropping while granted must not revoke the grant.
        paused = 0;
        repeat (3) begin step(); chk("grant_held", hs_grant, 1'b1); end
        paused = 1;

        // Intent returns inside the hold-off window.
        hs_access_read = 0;
        repeat (3) step();
        chk("hold_pause", pause_req, 1'b1);
        chk("hold_nogrant", hs_grant, 1'b0);
        hs_access_write = 1;
        k = 0; flag = 0;
        while (!hs_grant && k < 20) begin step(); k++; if (!pause_req) flag = 1; end
        chk("reacquire_latency", k, SETTLE);
        chk("pause_never_dropped", flag, 1'b0);

        // Asynchronous reset in the middle of a grant.
        hs_address = 16'h8A05; cpu_addr = 16'h8A1F;
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_grant", hs_grant, 1'b0);
        chk("rst_mid_pause", pause_req, 1'b0);
        chk("rst_mid_addr", ram_addr, 16'h8A1F);
        hs_access_write = 0;
        #2 rst_n = 1'b1;
        step(); step();
        chk("idle_after_reset", pause_req, 1'b0);

        // A one-cycle cpu_cs pulse restarts the settle window.
        hs_access_read = 1; paused = 1; cpu_cs = 0;
        step(); step(); step();
        cpu_cs = 1;
        step();
        cpu_cs = 0;
        k = 1;
        while (!hs_grant && k < 20) begin step(); k++; end
        chk("settle_restart", k, SETTLE);

        hs_access_read = 0;
        k = 0;
        while (pause_req && k < 50) begin step(); k++; end
        chk("holdoff_len", k, HOLDOFF + 1);
        step();
        chk("idle_gap", pause_req, 1'b0);

        // Pause never acknowledged.
        paused = 0; hs_access_read = 1;
        step();
        chk("timeout_req", pause_req, 1'b1);
        k = 0; flag = 0;
        while (pause_req && k < 200) begin step(); k++; if (hs_grant) flag = 1; end
        chk("timeout_len", k, TIMEOUT);
        chk("timeout_err", hs_error, 1'b1);
        chk("timeout_nogrant", flag, 1'b0);
        hs_access_read = 0;
        step(); step();
        chk("err_sticky", hs_error, 1'b1);
        chk("err_pause_low", pause_req, 1'b0);
        chk("err_cpu_owns", ram_addr, cpu_addr);

        #3 rst_n = 1'b0;
        model_reset();
        #1;
        chk("err_cleared", hs_error, 1'b0);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                if (hs_access_read | hs_access_write) begin
                    hs_access_read = 0; hs_access_write = 0;
                end else if ($urandom_range(0, 1) == 1) hs_access_read = 1;
                else hs_access_write = 1;
            end
            if ($urandom_range(0, 7) == 0) paused = ~paused;
            cpu_cs     = ($urandom_range(0, 3) == 0);
            cpu_we     = 1'($urandom_range(0, 1));
            cpu_addr   = 16'h8A00 + 16'($urandom_range(0, 31));
            cpu_din    = 8'($urandom);
            hs_address = 16'h8A00 + 16'($urandom_range(0, 31));
            hs_data_in = 8'($urandom);
            hs_write   = ($urandom_range(0, 3) == 0);
            step();
            if (i % 500 == 0)
                $display("rand %0d: grant=%0d pause=%0d err=%0d", i, hs_grant, pause_req, hs_error);
        end

        for (int i = 0; i < 32; i++)
            chk($sformatf("mem_%h", 16'h8A00 + 16'(i)), mem[16'h8A00 + 16'(i)], shadow[16'h8A00 + i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
